instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Instruction fetch (IF) stage of the RV32IM pipeline.
- Owns the PC and fetches 32-bit instructions from instruction memory over a req/ack handshake.
- Presents a registered {valid, pc, pc_plus4, instruction} bundle to the IF/ID boundary, which is consumed directly by the instruction decoder.
- Handles back-pressure (stall) from the hazard unit and PC redirects from branch/jump resolution.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
PC_STEP, 4, sequential PC increment in bytes.

Ports:
CLK  in  1  pipeline clock, rising edge.
RESET  in  1  asynchronous, active-high reset.
imem_req  out  1  fetch request to instruction memory.
imem_addr  out  32  fetch address; always equals the current PC.
imem_ack  in  1  imem_rdata is valid for the current imem_addr in this cycle.
imem_rdata  in  32  instruction word.
stall  in  1  downstream cannot accept; the output bundle must hold.
redirect_valid  in  1  branch/jump taken; flush and reload the PC.
redirect_pc  in  32  redirect target.
if_valid  out  1  output bundle holds a live instruction.
if_pc  out  32  PC of if_instruction.
if_pc_plus4  out  32  if_pc + PC_STEP.
if_instruction  out  32  fetched instruction.

Behaviour:
- Clock and reset: one clock, CLK. RESET is asynchronous and active-high.
- Reset values: pc=RESET_PC; state=RUN; if_valid=0; if_pc=0; if_pc_plus4=0; if_instruction=32'h0000_0013 (NOP); hold buffer empty. Assertion of RESET mid-fetch or mid-stall discards everything immediately.
- Memory protocol:
  - Memory is stateless. ack refers only to the address presented in the same cycle.
  - req/addr may change or drop on any cycle without an ack; no abort handshake is needed.
  - Zero-wait-state ack sustains 1 instruction per cycle.
- FSM states: RUN, HOLD.
- RUN: imem_req=1.
  - ack && !stall: output bundle <= {1, pc, pc+4, rdata}; pc <= pc+4.
  - ack && stall: rdata/pc go into the hold buffer; pc <= pc+4; output holds; go to HOLD.
  - !ack && !stall: if_valid <= 0 (bubble); pc unchanged.
  - !ack && stall: output holds.
- HOLD: imem_req=0; pc frozen.
  - !stall: output <= hold buffer; buffer cleared; go to RUN.
  - stall: remain in HOLD.
- Redirect has the highest priority in both states:
  - pc <= {redirect_pc[31:2],2'b00}.
  - if_valid <= 0 even if stall=1 (a flush overrides a stall).
  - Hold buffer cleared; state <= RUN.
  - An ack in the same cycle is discarded.
- Latency: instruction appears on the if_* outputs on the clock edge after its ack (1 cycle).
- Arithmetic: the PC adds wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0). No exceptions are raised.
- While stall=1 and no redirect, all if_* outputs are bit-stable.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds output port fetch_bubble_count (32 bits). It increments on every cycle where if_valid=0 and RESET is low, saturates at 32'hFFFF_FFFF, and resets to 0.
- Undefined: the port and counter are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package fetch_pkg holds:
  - RESET_PC default.
  - PC_STEP.
  - NOP encoding 32'h0000_0013.
  - FSM state typedef {RUN, HOLD}.
- One sub-module is natural: fetch_hold_buffer, a 1-entry {pc, instruction} register with load/clear/valid.

Test Plan:
- Reset then ack held high, stall=0 -> if_pc sequence 0,4,8,12 on consecutive cycles; if_valid=1 from the second edge onward.
- ack low for 2 cycles at pc=8 -> two cycles of if_valid=0; imem_addr stays 8; then if_pc=8 with the correct rdata.
- stall=1 for 3 cycles while ack=1 at pc=0x10 -> outputs frozen; imem_req=0 during HOLD; after release, if_pc=0x10 followed by 0x14 with no loss or duplication.
- redirect_valid with redirect_pc=0x103 while stall=1 and in HOLD -> next cycle if_valid=0, imem_addr=0x100, buffer dropped; ack at 0x100 yields if_pc=0x100.
- RESET_PC=32'hFFFF_FFFC, ack=1 -> if_pc=FFFF_FFFC with if_pc_plus4=0, then if_pc=0.
- Async RESET pulse mid-cycle during HOLD -> outputs return to reset values immediately; with FETCH_PERF_CNT_EN, fetch_bubble_count=0, then counts the bubble cycles.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants, FSM state type and IF/ID bundle layout for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEFAULT = 4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instruction;
  } if_bundle_t;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry {pc, instruction} parking register for a word acked while the stage is stalled.
module fetch_hold_buffer
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_instruction,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instruction
);

  // Clear wins over load so a flush can never leave a stale entry behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid       <= 1'b0;
      pc          <= '0;
      instruction <= NOP_INSTR;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid       <= 1'b1;
      pc          <= load_pc;
      instruction <= load_instruction;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, fetches over req/ack and drives the registered IF/ID bundle.
// Optional fetch bubble counter enabled by defining FETCH_PERF_CNT_EN.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic            CLK,
  input  logic            RESET,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic [XLEN-1:0] if_instruction
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] fetch_bubble_count
`endif
);

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  if_bundle_t      bundle, bundle_next;

  logic            buf_load, buf_clear, buf_valid;
  logic [XLEN-1:0] buf_pc, buf_instruction;

  fetch_hold_buffer u_hold_buffer (
    .clk              (CLK),
    .rst              (RESET),
    .load             (buf_load),
    .clear            (buf_clear),
    .load_pc          (pc),
    .load_instruction (imem_rdata),
    .valid            (buf_valid),
    .pc               (buf_pc),
    .instruction      (buf_instruction)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= RUN;
      pc     <= RESET_PC;
      bundle <= '{valid: 1'b0, pc: '0, pc_plus4: '0, instruction: NOP_INSTR};
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      bundle <= bundle_next;
    end
  end

  // Redirect outranks everything, including a stall and a same-cycle ack.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    bundle_next = bundle;
    buf_load    = 1'b0;
    buf_clear   = 1'b0;
    if (redirect_valid) begin
      pc_next           = align_pc(redirect_pc);
      bundle_next.valid = 1'b0;
      buf_clear         = 1'b1;
      state_next        = RUN;
    end else begin
      case (state)
        RUN: begin
          if (imem_ack) begin
            pc_next = pc + STEP;
            if (stall) begin
              buf_load   = 1'b1;
              state_next = HOLD;
            end else begin
              bundle_next = '{1'b1, pc, pc + STEP, imem_rdata};
            end
          end else if (!stall) begin
            bundle_next.valid = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            bundle_next = '{buf_valid, buf_pc, buf_pc + STEP, buf_instruction};
            buf_clear   = 1'b1;
            state_next  = RUN;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  assign imem_req       = (state == RUN);
  assign imem_addr      = pc;
  assign if_valid       = bundle.valid;
  assign if_pc          = bundle.pc;
  assign if_pc_plus4    = bundle.pc_plus4;
  assign if_instruction = bundle.instruction;

`ifdef FETCH_PERF_CNT_EN
  // Saturating count of cycles with no live instruction at the IF/ID boundary.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fetch_bubble_count <= '0;
    end else if (!bundle.valid && (fetch_bubble_count != '1)) begin
      fetch_bubble_count <= fetch_bubble_count + XLEN'(1);
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table, async reset case and a
// randomized run against a queue-based reference model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        ack = 1'b0, stall = 1'b0, rv = 1'b0;
  logic [31:0] rpc = 32'h0;
  logic        req;
  logic [31:0] addr, rdata;
  logic        o_valid;
  logic [31:0] o_pc, o_pc4, o_ins;

  logic        ack2 = 1'b1, stall2 = 1'b0, rv2 = 1'b0;
  logic [31:0] rpc2 = 32'h0;
  logic        req2;
  logic [31:0] addr2, rdata2;
  logic        o_valid2;
  logic [31:0] o_pc2, o_pc42, o_ins2;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cnt, cnt2;
`endif

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  assign rdata  = mem_word(addr);
  assign rdata2 = mem_word(addr2);

  instruction_fetch_unit dut (
    .CLK(CLK), .RESET(RESET), .imem_req(req), .imem_addr(addr), .imem_ack(ack),
    .imem_rdata(rdata), .stall(stall), .redirect_valid(rv), .redirect_pc(rpc),
    .if_valid(o_valid), .if_pc(o_pc), .if_pc_plus4(o_pc4), .if_instruction(o_ins)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_bubble_count(cnt)
`endif
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .CLK(CLK), .RESET(RESET), .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2),
    .imem_rdata(rdata2), .stall(stall2), .redirect_valid(rv2), .redirect_pc(rpc2),
    .if_valid(o_valid2), .if_pc(o_pc2), .if_pc_plus4(o_pc42), .if_instruction(o_ins2)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_bubble_count(cnt2)
`endif
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a PC, the visible bundle, and a queue of words parked during a stall.
  typedef struct {logic [31:0] pc; logic [31:0] ins;} parked_t;
  parked_t     m_q[$];
  logic [31:0] m_pc, m_opc, m_opc4, m_ins, m_cnt;
  logic        m_valid;

  task automatic model_reset();
    m_pc = 32'h0; m_valid = 1'b0; m_opc = 32'h0; m_opc4 = 32'h0; m_ins = NOP;
    m_cnt = 32'h0; m_q.delete();
  endtask

  task automatic model_step(input logic a, input logic s, input logic r, input logic [31:0] rp);
    parked_t p;
    if (!m_valid && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    if (r) begin
      m_pc = rp & 32'hFFFF_FFFC;
      m_valid = 1'b0;
      m_q.delete();
    end else if (m_q.size() != 0) begin
      if (!s) begin
        p = m_q.pop_front();
        m_valid = 1'b1; m_opc = p.pc; m_opc4 = p.pc + 4; m_ins = p.ins;
      end
    end else if (a) begin
      if (s) begin
        p.pc = m_pc; p.ins = mem_word(m_pc);
        m_q.push_back(p);
      end else begin
        m_valid = 1'b1; m_opc = m_pc; m_opc4 = m_pc + 4; m_ins = mem_word(m_pc);
      end
      m_pc = m_pc + 4;
    end else if (!s) begin
      m_valid = 1'b0;
    end
  endtask

  // Called at a falling edge: drive, check fetch side, clock, check bundle.
  task automatic cycle(input logic a, input logic s, input logic r, input logic [31:0] rp);
    ack = a; stall = s; rv = r; rpc = rp;
    #1;
    check("imem_req", {31'b0, req}, {31'b0, (m_q.size() == 0)});
    check("imem_addr", addr, m_pc);
    @(posedge CLK);
    model_step(a, s, r, rp);
    @(negedge CLK);
    check("if_valid", {31'b0, o_valid}, {31'b0, m_valid});
    check("if_pc", o_pc, m_opc);
    check("if_pc_plus4", o_pc4, m_opc4);
    check("if_instruction", o_ins, m_ins);
`ifdef FETCH_PERF_CNT_EN
    check("fetch_bubble_count", cnt, m_cnt);
`endif
  endtask

  typedef struct {
    logic a, s, r; logic [31:0] rp;
    logic e_req; logic [31:0] e_addr;
    logic e_valid; logic [31:0] e_pc;
  } vec_t;

  function automatic vec_t mk(input logic a, input logic s, input logic r, input logic [31:0] rp,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_pc);
    vec_t v;
    v.a = a; v.s = s; v.r = r; v.rp = rp;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
    return v;
  endfunction

  vec_t tbl[16];

  initial begin
    tbl[0]  = mk(1, 0, 0, 32'h0,   1, 32'h00,  1, 32'h00);
    tbl[1]  = mk(1, 0, 0, 32'h0,   1, 32'h04,  1, 32'h04);
    tbl[2]  = mk(0, 0, 0, 32'h0,   1, 32'h08,  0, 32'h0);
    tbl[3]  = mk(0, 0, 0, 32'h0,   1, 32'h08,  0, 32'h0);
    tbl[4]  = mk(1, 0, 0, 32'h0,   1, 32'h08,  1, 32'h08);
    tbl[5]  = mk(1, 0, 0, 32'h0,   1, 32'h0C,  1, 32'h0C);
    tbl[6]  = mk(1, 1, 0, 32'h0,   1, 32'h10,  1, 32'h0C);
    tbl[7]  = mk(1, 1, 0, 32'h0,   0, 32'h14,  1, 32'h0C);
    tbl[8]  = mk(1, 1, 0, 32'h0,   0, 32'h14,  1, 32'h0C);
    tbl[9]  = mk(1, 0, 0, 32'h0,   0, 32'h14,  1, 32'h10);
    tbl[10] = mk(1, 0, 0, 32'h0,   1, 32'h14,  1, 32'h14);
    tbl[11] = mk(1, 1, 0, 32'h0,   1, 32'h18,  1, 32'h14);
    tbl[12] = mk(0, 1, 1, 32'h103, 0, 32'h1C,  0, 32'h0);
    tbl[13] = mk(1, 0, 0, 32'h0,   1, 32'h100, 1, 32'h100);
    tbl[14] = mk(1, 0, 1, 32'h200, 1, 32'h104, 0, 32'h0);
    tbl[15] = mk(1, 0, 0, 32'h0,   1, 32'h200, 1, 32'h200);

    model_reset();
    @(negedge CLK);
    check("reset if_valid", {31'b0, o_valid}, 32'h0);
    check("reset if_pc", o_pc, 32'h0);
    check("reset if_pc_plus4", o_pc4, 32'h0);
    check("reset if_instruction", o_ins, NOP);
    check("reset imem_addr wrap", addr2, 32'hFFFF_FFFC);
    RESET = 1'b0;

    for (int i = 0; i < 16; i++) begin
      ack = tbl[i].a; stall = tbl[i].s; rv = tbl[i].r; rpc = tbl[i].rp;
      #1;
      check($sformatf("vec%0d imem_req", i), {31'b0, req}, {31'b0, tbl[i].e_req});
      check($sformatf("vec%0d imem_addr", i), addr, tbl[i].e_addr);
      cycle(tbl[i].a, tbl[i].s, tbl[i].r, tbl[i].rp);
      check($sformatf("vec%0d if_valid", i), {31'b0, o_valid}, {31'b0, tbl[i].e_valid});
      if (tbl[i].e_valid) begin
        check($sformatf("vec%0d if_pc", i), o_pc, tbl[i].e_pc);
        check($sformatf("vec%0d if_pc_plus4", i), o_pc4, tbl[i].e_pc + 32'd4);
        check($sformatf("vec%0d if_instruction", i), o_ins, mem_word(tbl[i].e_pc));
      end
      if (i == 0) begin
        check("wrap if_pc first", o_pc2, 32'hFFFF_FFFC);
        check("wrap if_pc_plus4 first", o_pc42, 32'h0);
      end
      if (i == 1) begin
        check("wrap if_pc second", o_pc2, 32'h0);
        check("wrap if_pc_plus4 second", o_pc42, 32'h4);
      end
    end

    // Park a word, then hit reset asynchronously between clock edges.
    cycle(1, 1, 0, 32'h0);
    #2 RESET = 1'b1;
    #1;
    check("async if_valid", {31'b0, o_valid}, 32'h0);
    check("async if_pc", o_pc, 32'h0);
    check("async if_instruction", o_ins, NOP);
    check("async imem_req", {31'b0, req}, 32'h1);
    check("async imem_addr", addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("async bubble count", cnt, 32'h0);
`endif
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 32'h0);
    cycle(1, 0, 0, 32'h0);

    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 19) == 0), $urandom());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
